// File: rtl/accumulator_8bit.sv
// accumulator_8bit: burst accumulator over a valid/ready handshake with a sticky overflow flag.
// Define ACCUM_SATURATE_EN to clamp the total at 0xFF on carry-out instead of wrapping.
module adder_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       carry_in,
    output logic [7:0] sum,
    output logic       overflow
);
    assign {overflow, sum} = {1'b0, a} + {1'b0, b} + {8'b0, carry_in};
endmodule

module accumulator_8bit #(
    parameter int NUM_OPERANDS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       overflow
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    localparam logic [3:0] LAST = 4'(NUM_OPERANDS - 1);
    state_t     state_q;
    logic [7:0] acc_q, acc_d, sum;
    logic [3:0] cnt_q;
    logic       ovf_q, add_ovf, done_q, in_ready_q, busy_q;
    logic       accept;
    adder_8bit u_adder (
        .a       (acc_q),
        .b       (in_data),
        .carry_in(1'b0),
        .sum     (sum),
        .overflow(add_ovf)
    );
    assign accept = in_valid & in_ready_q;
`ifdef ACCUM_SATURATE_EN
    assign acc_d = add_ovf ? 8'hFF : sum;
`else
    assign acc_d = sum;
`endif
    // Handshake outputs are registered alongside the state so they never depend on inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= 8'h00;
            cnt_q      <= 4'd0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_q    <= ACCUM;
                    acc_q      <= 8'h00;
                    cnt_q      <= 4'd0;
                    ovf_q      <= 1'b0;
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b1;
                end
                ACCUM: if (accept) begin
                    acc_q <= acc_d;
                    ovf_q <= ovf_q | add_ovf;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == LAST) begin
                        state_q    <= DONE;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end
    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = acc_q;
    assign overflow = ovf_q;
endmodule
